// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot loader: the loader state encoding and the
// image framing constants (bytes per instruction word, bytes in the length
// header).
// Optional feature macro used by the loader: BOOT_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 4;

endpackage

// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
// Groups the byte-stream handshake and the instruction-memory write port.
//   rx_data / rx_valid / rx_ready : byte stream, transfer on valid && ready
//   imem_write_enable / imem_address / imem_write_data : one-word write port
// Modports:
//   master : byte source side (drives rx_data/rx_valid, observes the rest)
//   slave  : boot loader side
// ---------------------------------------------------------------------------
interface boot_loader_if #(
    parameter int data_bits           = 32,
    parameter int memory_address_bits = 10
);
    logic [7:0]                     rx_data;
    logic                           rx_valid;
    logic                           rx_ready;
    logic                           imem_write_enable;
    logic [memory_address_bits-1:0] imem_address;
    logic [data_bits-1:0]           imem_write_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_write_enable, imem_address, imem_write_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_write_enable, imem_address, imem_write_data
    );
endinterface

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Shifts accepted bytes into a 32-bit little-endian word: the first byte of
// a group of four ends up in bits [7:0].
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : a byte is accepted this cycle
//   in_byte     : the byte
//   word_next   : word including the byte accepted this cycle
//   word_full   : pulse, this cycle's byte completes a word
// ---------------------------------------------------------------------------
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (in_valid) begin
            // Shift right so the oldest byte lands in the low lane after four.
            word_d = {in_byte, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
        end
    end

    // Completion is decoded from the pre-increment index so the consumer
    // sees the full word in the same cycle as the 4th byte.
    assign word_full = in_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_next = word_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
// Receives a program image as a byte stream (4-byte LE word count N, then N
// LE words) and writes it into instruction memory one word per strobe. The
// core is held in reset until the image is complete.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : rx byte handshake + imem write port (boot_loader_if)
//   core_reset    : reset to the core, high until load completes
//   boot_done     : image loaded, core released (sticky)
//   boot_error    : image rejected, core held (sticky)
//   words_loaded  : number of words written so far
// Optional feature: define BOOT_LOADER_CHECKSUM_EN to require a trailing
// byte equal to the XOR of all data bytes before releasing the core.
// ---------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int data_bits           = 32,
    parameter int memory_size         = 1024,
    parameter int memory_address_bits = $clog2(memory_size)
) (
    input  logic                         clk,
    input  logic                         reset,
    boot_loader_if.slave                 bus,
    output logic                         core_reset,
    output logic                         boot_done,
    output logic                         boot_error,
    output logic [memory_address_bits:0] words_loaded
);

    localparam int CNT_W = memory_address_bits + 1;

    state_e                         state_q, state_d;
    logic                           rx_ready_q, rx_ready_d;
    logic                           we_q, we_d;
    logic [memory_address_bits-1:0] addr_q, addr_d;
    logic [data_bits-1:0]           wdata_q, wdata_d;
    logic                           core_reset_q, core_reset_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;
    logic [CNT_W-1:0]               words_q, words_d;
    logic [CNT_W-1:0]               n_q, n_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]                     csum_q, csum_d;
`endif

    logic        accept;
    logic        pack_valid;
    logic [31:0] word_next;
    logic        word_full;

    assign accept     = bus.rx_valid && rx_ready_q;
    assign pack_valid = accept && ((state_q == LEN) || (state_q == LOAD));

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (pack_valid),
        .in_byte   (bus.rx_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        words_d = words_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            LEN: begin
                if (word_full) begin
                    n_d = word_next[CNT_W-1:0];
                    if (word_next > 32'(memory_size)) begin
                        state_d = ERROR;
                    end else if (word_next == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ bus.rx_data;
                end
`endif
                // Address and data are captured here so they are already
                // stable during the single WRITE cycle and held afterwards.
                if (word_full) begin
                    state_d = WRITE;
                    addr_d  = words_q[memory_address_bits-1:0];
                    wdata_d = word_next[data_bits-1:0];
                end
            end
            WRITE: begin
                words_d = words_q + 1'b1;
                if (words_d == n_q) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (bus.rx_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        // All outputs are registered and decoded from the next state, so they
        // line up with the state they describe.
        we_d         = (state_d == WRITE);
        rx_ready_d   = (state_d == LEN) || (state_d == LOAD) || (state_d == CHK);
        core_reset_d = (state_d != DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LEN;
            rx_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
            n_q          <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            words_q      <= words_d;
            n_q          <= n_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.rx_ready          = rx_ready_q;
    assign bus.imem_write_enable = we_q;
    assign bus.imem_address      = addr_q;
    assign bus.imem_write_data   = wdata_q;
    assign core_reset            = core_reset_q;
    assign boot_done             = done_q;
    assign boot_error            = error_q;
    assign words_loaded          = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader
// Scoreboard bench for boot_loader (memory_size = 512). Expected writes are
// queued as each image word is sent and compared as write strobes appear.
// Builds with or without BOOT_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_boot_loader;

    localparam int MS = 512;
    localparam int AB = $clog2(MS);

    typedef struct {
        logic [AB-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_reset, boot_done, boot_error;
    logic [AB:0] words_loaded;

    boot_loader_if #(.data_bits(32), .memory_address_bits(AB)) bus ();

    boot_loader #(.data_bits(32), .memory_size(MS)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .core_reset   (core_reset),
        .boot_done    (boot_done),
        .boot_error   (boot_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_pass  = 0;
    int         wr_count = 0;
    logic [7:0] tb_csum = 8'd0;
    wr_t        sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write-port monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.imem_write_enable === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(bus.imem_address), 64'hFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(bus.imem_address), 64'(e.a));
                chk("wr_data", 64'(bus.imem_write_data), 64'(e.d));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_boot_done", 64'(boot_done), 64'd0);
        chk("rst_boot_error", 64'(boot_error), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        chk("rst_we", 64'(bus.imem_write_enable), 64'd0);
        chk("rst_addr", 64'(bus.imem_address), 64'd0);
        chk("rst_data", 64'(bus.imem_write_data), 64'd0);
        sb.delete();
        wr_count = 0;
        tb_csum  = 8'd0;
        reset = 1'b0;
        tick();
        chk("rst_rx_ready_rise", 64'(bus.rx_ready), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.rx_ready) begin
            chk("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
            bus.rx_valid = 1'b0;
            return;
        end
        tick();
        bus.rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.rx_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic load_word(input int addr, input logic [31:0] w, input int gap);
        wr_t e;
        e.a = AB'(addr);
        e.d = w;
        sb.push_back(e);
        tb_csum = tb_csum ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        send_word(w, gap);
    endtask

    // Brings the loader from its last data step into DONE.
    task automatic end_image(input bit settle);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(tb_csum, 0);
`else
        if (settle) tick();
`endif
    endtask

    task automatic check_done(input string tag, input int n);
        chk({tag, "_done"}, 64'(boot_done), 64'd1);
        chk({tag, "_core_reset"}, 64'(core_reset), 64'd0);
        chk({tag, "_error"}, 64'(boot_error), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'(n));
        chk({tag, "_wr_count"}, 64'(wr_count), 64'(n));
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Two words, back-to-back bytes.
        do_reset();
        send_word(32'd2, 0);
        load_word(0, 32'h00500093, 0);
        load_word(1, 32'h00A00113, 0);
`ifndef BOOT_LOADER_CHECKSUM_EN
        chk("t1_we_in_write", 64'(bus.imem_write_enable), 64'd1);
        chk("t1_core_reset_in_write", 64'(core_reset), 64'd1);
`endif
        end_image(1);
        check_done("t1", 2);
        tick();
        chk("t1_rx_ready_done", 64'(bus.rx_ready), 64'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        for (int i = 0; i < 6; i++) tick();
        bus.rx_valid = 1'b0;
        check_done("t1_ignore", 2);

        // Oversized length: 1023 > 512.
        do_reset();
        send_word(32'h000003FF, 0);
        chk("t2_error", 64'(boot_error), 64'd1);
        chk("t2_core_reset", 64'(core_reset), 64'd1);
        chk("t2_done", 64'(boot_done), 64'd0);
        tick();
        chk("t2_rx_ready", 64'(bus.rx_ready), 64'd0);
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.rx_valid = 1'b0;
        chk("t2_no_write", 64'(wr_count), 64'd0);
        chk("t2_core_reset_held", 64'(core_reset), 64'd1);

        // One past capacity is rejected.
        do_reset();
        send_word(32'(MS + 1), 0);
        chk("t2b_error", 64'(boot_error), 64'd1);

        // Exactly full memory: last address MS-1, count MS without wrap.
        do_reset();
        send_word(32'(MS), 0);
        for (int i = 0; i < MS; i++) load_word(i, $urandom, 0);
        end_image(1);
        check_done("t2c", MS);

        // Empty image.
        do_reset();
        send_word(32'd0, 0);
        end_image(0);
        check_done("t3", 0);

        // Gapped bytes (valid 1-0-0-1).
        do_reset();
        send_word(32'd1, 2);
        load_word(0, 32'hDEADBEEF, 2);
        end_image(1);
        check_done("t4", 1);

        // Reset in the middle of word 1, then full reload.
        do_reset();
        send_word(32'd3, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset();
        send_word(32'd3, 1);
        load_word(0, 32'hCAFEF00D, 0);
        load_word(1, 32'h01234567, 1);
        load_word(2, 32'h89ABCDEF, 0);
        end_image(1);
        check_done("t5", 3);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Correct and incorrect checksum for word 0x12345678 (XOR = 0x08).
        do_reset();
        send_word(32'd1, 0);
        load_word(0, 32'h12345678, 0);
        send_byte(8'h08, 0);
        check_done("t6_ok", 1);

        do_reset();
        send_word(32'd1, 0);
        load_word(0, 32'h12345678, 0);
        send_byte(8'h09, 0);
        chk("t6_bad_error", 64'(boot_error), 64'd1);
        chk("t6_bad_core_reset", 64'(core_reset), 64'd1);
        chk("t6_bad_done", 64'(boot_done), 64'd0);
`endif

        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream of the processor core. Receives a program image as a byte stream and writes it into the core's instruction memory one 32-bit word at a time.
- Holds the core in reset until the image is complete.
- Sits between a byte source (UART receiver or testbench) and the instruction-memory write port.
- Drives the core's `reset` input.

Parameters:
- data_bits, 32, instruction word width; must be 32.
- memory_size, 1024, instruction memory depth in words.
- memory_address_bits, $clog2(memory_size), word-index width of imem_address.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready
- imem_write_enable  output  1  one-cycle write strobe to instruction memory
- imem_address  output  memory_address_bits  word index being written
- imem_write_data  output  data_bits  word being written
- core_reset  output  1  reset to the core; high until load completes
- boot_done  output  1  image loaded; core released
- boot_error  output  1  image rejected; core held in reset
- words_loaded  output  memory_address_bits+1  count of words written so far

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = LEN, rx_ready = 0
  - imem_write_enable = 0, imem_address = 0, imem_write_data = 0
  - core_reset = 1, boot_done = 0, boot_error = 0, words_loaded = 0
  - byte counter = 0, word count N = 0
- rx_ready is a registered output:
  - 1 in LEN and LOAD (and CHK when enabled).
  - 0 in WRITE, DONE and ERROR.
  - It rises the cycle after reset deasserts.
- Image format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian. Byte 0 goes to bits [7:0].
- States:
  - LEN: shift accepted bytes into N. On the 4th accepted byte, the next state is:
    - ERROR if N > memory_size;
    - DONE if N == 0;
    - LOAD otherwise.
  - LOAD: assemble accepted bytes into a word buffer. On the 4th byte of a word, go to WRITE.
  - WRITE (exactly one cycle):
    - imem_write_enable = 1; imem_address = words_loaded[memory_address_bits-1:0]; imem_write_data = buffer.
    - words_loaded increments at the end of this cycle.
    - If the new words_loaded == N, go to DONE (or CHK when enabled); otherwise return to LOAD.
  - DONE:
    - core_reset = 0, boot_done = 1. The state is sticky until reset.
    - Further rx_valid is ignored (rx_ready = 0).
  - ERROR: boot_error = 1, core_reset = 1. The state is sticky until reset.
- Latency:
  - The write strobe appears one cycle after the 4th byte of a word is accepted.
  - core_reset falls one cycle after the final WRITE cycle (or after the final LEN byte when N == 0).
- rx_valid low: no state change and no partial-byte loss. Bytes may arrive with arbitrary gaps.
- Maximum rate: 4 bytes per 5 cycles. rx_ready low in WRITE provides the back-pressure.
- N == memory_size is legal. The last write uses address memory_size-1, and words_loaded reaches memory_size without wrap.
- Reset mid-load:
  - All state is cleared and core_reset returns to 1 in the same edge.
  - Partially assembled bytes are discarded.
  - Instruction-memory contents are not cleared.
- imem_address and imem_write_data hold their last values outside WRITE. Only imem_write_enable qualifies them.

Optional Feature:
- Macro BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, state CHK accepts one extra byte.
  - The expected value is the XOR of all N*4 data bytes. Length bytes are excluded.
  - Match goes to DONE; mismatch goes to ERROR. Either transition happens the cycle after the byte is accepted.
  - With N == 0, CHK is still entered and expects 0x00.
- Undefined: no CHK state, no checksum register. DONE follows the last WRITE directly.

Decomposition:
- Shared package boot_pkg:
  - state enum: LEN, LOAD, WRITE, CHK, DONE, ERROR.
  - BYTES_PER_WORD = 4.
  - LEN_BYTES = 4.
- Sub-module byte_packer: shifts 8-bit inputs into a 32-bit little-endian word, with a 2-bit index and a word_full pulse. It is used by both the LEN and LOAD states.

Test Plan:
- Load N=2 with words 0x00500093, 0x00A00113, bytes sent back-to-back (rx_valid held 1):
  - writes occur at address 0 then 1 with those values;
  - words_loaded = 2;
  - core_reset falls the cycle after the 2nd WRITE;
  - boot_done = 1.
- Length bytes FF 03 00 00 (N=1023, i.e. > memory_size-1 only when memory_size=512). Run with memory_size=512:
  - boot_error = 1;
  - rx_ready = 0;
  - no imem_write_enable pulse;
  - core_reset stays 1.
- N=0 (bytes 00 00 00 00): boot_done = 1 one cycle after the 4th byte, with zero writes. With CHECKSUM_EN, it needs trailing byte 0x00 instead.
- N=1 with rx_valid toggling 1-0-0-1 between bytes: word assembled correctly, single write to address 0, no duplicated or dropped byte.
- Assert reset after 2 bytes of word 1 of N=3, then re-send the full image: the load restarts from LEN, and the first write after reset goes to address 0.
- CHECKSUM_EN, N=1, word 0x12345678, checksum byte 0x08 → boot_done. Repeat with checksum 0x09 → boot_error, core_reset stays 1.
